// File: rtl/fp_regfile.sv
// Coprocessor-1 floating-point register file: 32 x 32-bit, single or even/odd double access.
// Optional FP_REGFILE_BYPASS_EN forwards same-cycle write data into the read ports per word.
module fp_regfile #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        rs_addr,
    input  logic [4:0]        rt_addr,
    input  logic              rd_double,
    output logic [DATA_W-1:0] rd0_0,
    output logic [DATA_W-1:0] rd0_1,
    output logic [DATA_W-1:0] rd1_0,
    output logic [DATA_W-1:0] rd1_1,
    input  logic              we,
    input  logic [4:0]        wr_addr,
    input  logic              wr_double,
    input  logic [DATA_W-1:0] wd_0,
    input  logic [DATA_W-1:0] wd_1
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            if (wr_double) begin
                regs_d[{wr_addr[4:1], 1'b1}] = wd_0;
                regs_d[{wr_addr[4:1], 1'b0}] = wd_1;
            end else begin
                regs_d[wr_addr] = wd_0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Value seen by a read of one register this cycle.
    function automatic logic [DATA_W-1:0] read_word(input logic [4:0] idx);
        logic [DATA_W-1:0] w;
        w = regs_q[idx];
`ifdef FP_REGFILE_BYPASS_EN
        if (we && rst_n) begin
            if (wr_double && (idx[4:1] == wr_addr[4:1])) begin
                w = idx[0] ? wd_0 : wd_1;
            end else if (!wr_double && (idx == wr_addr)) begin
                w = wd_0;
            end
        end
`endif
        return w;
    endfunction

    always_comb begin
        if (rd_double) begin
            rd0_0 = read_word({rs_addr[4:1], 1'b1});
            rd0_1 = read_word({rs_addr[4:1], 1'b0});
            rd1_0 = read_word({rt_addr[4:1], 1'b1});
            rd1_1 = read_word({rt_addr[4:1], 1'b0});
        end else begin
            rd0_0 = read_word(rs_addr);
            rd0_1 = '0;
            rd1_0 = read_word(rt_addr);
            rd1_1 = '0;
        end
    end

endmodule

// File: tb/tb_fp_regfile.sv
// Directed self-checking bench for fp_regfile; expectations follow FP_REGFILE_BYPASS_EN if defined.
module tb_fp_regfile;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        rd_double;
    logic [31:0] rd0_0;
    logic [31:0] rd0_1;
    logic [31:0] rd1_0;
    logic [31:0] rd1_1;
    logic        we;
    logic [4:0]  wr_addr;
    logic        wr_double;
    logic [31:0] wd_0;
    logic [31:0] wd_1;

    int n_checks = 0;
    int n_fail   = 0;

    fp_regfile #(
        .DATA_W   (32),
        .NUM_REGS (32)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rd_double (rd_double),
        .rd0_0     (rd0_0),
        .rd0_1     (rd0_1),
        .rd1_0     (rd1_0),
        .rd1_1     (rd1_1),
        .we        (we),
        .wr_addr   (wr_addr),
        .wr_double (wr_double),
        .wd_0      (wd_0),
        .wd_1      (wd_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic dbl, input logic [31:0] d0,
                             input logic [31:0] d1);
        we        = 1'b1;
        wr_addr   = a;
        wr_double = dbl;
        wd_0      = d0;
        wd_1      = d1;
        step();
        we        = 1'b0;
    endtask

    task automatic set_read(input logic [4:0] a0, input logic [4:0] a1, input logic dbl);
        rs_addr   = a0;
        rt_addr   = a1;
        rd_double = dbl;
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        we        = 1'b0;
        wr_addr   = '0;
        wr_double = 1'b0;
        wd_0      = '0;
        wd_1      = '0;
        rs_addr   = '0;
        rt_addr   = '0;
        rd_double = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        set_read(5'd31, 5'd0, 1'b1);
        check_eq("init_rd0_0", rd0_0, 32'h0);
        check_eq("init_rd1_1", rd1_1, 32'h0);

        // Preload then reset.
        for (int i = 0; i < 32; i++) write_reg(5'(i), 1'b0, 32'hA5A5A5A5, 32'h0);
        set_read(5'd7, 5'd6, 1'b1);
        check_eq("preload_f7", rd0_0, 32'hA5A5A5A5);
        check_eq("preload_f6", rd1_1, 32'hA5A5A5A5);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        set_read(5'd7, 5'd6, 1'b0);
        check_eq("rst_single_f7", rd0_0, 32'h0);
        check_eq("rst_single_rd0_1", rd0_1, 32'h0);
        set_read(5'd7, 5'd6, 1'b1);
        check_eq("rst_dbl_rd0_0", rd0_0, 32'h0);
        check_eq("rst_dbl_rd0_1", rd0_1, 32'h0);
        check_eq("rst_dbl_rd1_0", rd1_0, 32'h0);
        check_eq("rst_dbl_rd1_1", rd1_1, 32'h0);

        // Single write/read.
        write_reg(5'd3, 1'b0, 32'h3F800000, 32'hFFFFFFFF);
        set_read(5'd3, 5'd2, 1'b0);
        check_eq("single_rd0_0", rd0_0, 32'h3F800000);
        check_eq("single_rd0_1", rd0_1, 32'h0);
        check_eq("single_neighbour", rd1_0, 32'h0);

        // $f0 is writable.
        write_reg(5'd0, 1'b0, 32'hC0000000, 32'h0);
        set_read(5'd0, 5'd0, 1'b0);
        check_eq("f0_port0", rd0_0, 32'hC0000000);
        check_eq("f0_port1", rd1_0, 32'hC0000000);

        // Double write with odd address.
        write_reg(5'd5, 1'b1, 32'h40090000, 32'h12345678);
        set_read(5'd5, 5'd4, 1'b0);
        check_eq("dblw_f5", rd0_0, 32'h40090000);
        check_eq("dblw_f4", rd1_0, 32'h12345678);
        set_read(5'd0, 5'd4, 1'b1);
        check_eq("dblr4_hi", rd1_0, 32'h40090000);
        check_eq("dblr4_lo", rd1_1, 32'h12345678);
        check_eq("dblr0_hi", rd0_0, 32'h0);
        check_eq("dblr0_lo", rd0_1, 32'hC0000000);
        set_read(5'd5, 5'd5, 1'b1);
        check_eq("dblr5_hi", rd1_0, 32'h40090000);
        check_eq("dblr5_lo", rd1_1, 32'h12345678);
        check_eq("dblr5_p0_hi", rd0_0, 32'h40090000);
        check_eq("dblr5_p0_lo", rd0_1, 32'h12345678);

        // Same-cycle hazard on $f8.
        write_reg(5'd8, 1'b0, 32'h11111111, 32'h0);
        we        = 1'b1;
        wr_addr   = 5'd8;
        wr_double = 1'b0;
        wd_0      = 32'h22222222;
        set_read(5'd8, 5'd9, 1'b0);
`ifdef FP_REGFILE_BYPASS_EN
        check_eq("hazard_same", rd0_0, 32'h22222222);
`else
        check_eq("hazard_same", rd0_0, 32'h11111111);
`endif
        step();
        we = 1'b0;
        #1;
        check_eq("hazard_next", rd0_0, 32'h22222222);

        // Single write to half of a pair during a double read.
        we        = 1'b1;
        wr_addr   = 5'd4;
        wr_double = 1'b0;
        wd_0      = 32'hAAAA5555;
        set_read(5'd4, 5'd4, 1'b1);
        check_eq("overlap_hi", rd1_0, 32'h40090000);
`ifdef FP_REGFILE_BYPASS_EN
        check_eq("overlap_lo", rd1_1, 32'hAAAA5555);
`else
        check_eq("overlap_lo", rd1_1, 32'h12345678);
`endif
        step();
        we = 1'b0;
        #1;
        check_eq("overlap_after_lo", rd1_1, 32'hAAAA5555);

        // we=0 must not change state.
        write_reg(5'd9, 1'b0, 32'h00000009, 32'h0);
        we        = 1'b0;
        wr_addr   = 5'd9;
        wr_double = 1'b1;
        wd_0      = 32'hDEADBEEF;
        wd_1      = 32'hDEADBEEF;
        step();
        set_read(5'd9, 5'd8, 1'b0);
        check_eq("we0_f9", rd0_0, 32'h00000009);
        check_eq("we0_f8", rd1_0, 32'h22222222);

        // Reset beats a same-edge write.
        write_reg(5'd2, 1'b0, 32'h0000ABCD, 32'h0);
        rst_n     = 1'b0;
        we        = 1'b1;
        wr_addr   = 5'd2;
        wr_double = 1'b0;
        wd_0      = 32'hFFFFFFFF;
        set_read(5'd2, 5'd3, 1'b0);
        check_eq("rst_nofwd_f2", rd0_0, 32'h0000ABCD);
        step();
        rst_n = 1'b1;
        we    = 1'b0;
        #1;
        check_eq("rst_we_f2", rd0_0, 32'h0);
        check_eq("rst_we_f3", rd1_0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_regfile.md
Name: fp_regfile

Overview:
- Coprocessor-1 floating-point register file: 32 x 32-bit registers $f0..$f31.
- Sits directly upstream of the FP ALU:
  - Supplies operand pairs in0_0/in0_1 and in1_0/in1_1, single or double.
  - Accepts the ALU's ALUResult_0/ALUResult_1 pair as write-back data.
- Also serves mtc1/mfc1/lwc1/swc1 single-word traffic.
- Doubles occupy even/odd register pairs.

Parameters:
- DATA_W, 32, width of one register word; fixed at 32 for MIPS, other values unsupported.
- NUM_REGS, 32, number of registers; address width is 5.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  synchronous reset, active-low.
- rs_addr  input  5  read port 0 register number (fs).
- rt_addr  input  5  read port 1 register number (ft).
- rd_double  input  1  1 = both read ports return a 64-bit pair.
- rd0_0  output  32  port 0 high word (double) or the single value.
- rd0_1  output  32  port 0 low word (double); 0 in single mode.
- rd1_0  output  32  port 1 high word (double) or the single value.
- rd1_1  output  32  port 1 low word (double); 0 in single mode.
- we  input  1  write enable.
- wr_addr  input  5  write register number (fd).
- wr_double  input  1  1 = write a 64-bit pair.
- wd_0  input  32  write data high word (double) or the single value.
- wd_1  input  32  write data low word; ignored when wr_double=0.

Behaviour:
- Storage: regs[0..31], DATA_W bits each. $f0 is an ordinary writable register, not hardwired.
- Reset: when rst_n=0 at posedge clk, all 32 registers clear to 0. Read outputs therefore show 0 from the next cycle. Reset overrides any write in the same cycle. Asserting reset mid-sequence discards that cycle's write.
- Reads are combinational (single-cycle datapath): 0 cycles latency from address to data.
- Single read (rd_double=0):
  - rdX_0 = regs[addr]
  - rdX_1 = 32'h0
- Double read (rd_double=1):
  - Pair base p = {addr[4:1],1'b0}; addr[0] is ignored.
  - rdX_0 = regs[p+1] (odd register holds the high word, sign/exponent).
  - rdX_1 = regs[p] (even register holds the low word).
  - The ALU's 64-bit operand {rdX_0, rdX_1} is therefore {odd, even}.
- Write at posedge clk when we=1 and rst_n=1:
  - wr_double=0: regs[wr_addr] <= wd_0.
  - wr_double=1: with q = {wr_addr[4:1],1'b0}, regs[q+1] <= wd_0 and regs[q] <= wd_1. Both words update in the same edge. wr_addr[0] is ignored.
  - we=0: no state change, whatever the other write inputs are.
- Read/write same cycle, same register: the read returns the OLD value (write-first is not used). The new value is visible from the cycle after the edge. A double read overlapping a single write to half of the pair shows old data on both words that cycle.
- Both read ports may address the same register or pair; both return identical data.
- No X propagation: every output is a full function of stored state and addresses.

Optional Feature:
- Macro: FP_REGFILE_BYPASS_EN.
- Defined:
  - Same-cycle write-to-read forwarding, per 32-bit word. Any output word whose source register is being written this cycle (we=1, rst_n=1) shows the incoming write word instead of the stored one.
  - Applies to all single/double combinations, e.g. a single write to $f5 forwards into the high word of a double read of $f4.
  - Forwarding is disabled while rst_n=0.
- Not defined: read-old-value behaviour as stated above.

Test Plan:
- Reset: preload regs with 0xA5A5A5A5, hold rst_n=0 for 1 edge, read $f7 and double $f6 -> all read outputs 0.
- Single write/read: we=1, wr_addr=3, wd_0=0x3F800000; next cycle rs_addr=3, rd_double=0 -> rd0_0=0x3F800000, rd0_1=0.
- Double write, misaligned address: wr_double=1, wr_addr=5, wd_0=0x40090000, wd_1=0x12345678 -> $f5=0x40090000, $f4=0x12345678. Double read with rt_addr=4 and with rt_addr=5 -> rd1_0=0x40090000, rd1_1=0x12345678.
- Same-cycle hazard: $f8=0x11111111, then in the same cycle write $f8=0x22222222 and read rs_addr=8:
  - macro off -> rd0_0=0x11111111 that cycle, 0x22222222 next cycle.
  - macro on -> 0x22222222 that cycle.
- we=0 with wr_addr=9, wd_0=0xDEADBEEF -> $f9 keeps its prior value.
- Reset with we=1 in the same edge, writing $f2=0xFFFFFFFF -> $f2 reads 0 afterwards.
